// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the shared datapath.
// The master drives the controls; the slave supplies IR fields and status.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic [2:0] state;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic       alu_b;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, func, zero, mem_ready,
        output state, ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
               reg_dst, wd_sel, alu_op, ext_sel, alu_b, instr_done, illegal
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  state, ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
               reg_dst, wd_sel, alu_op, ext_sel, alu_b, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset core: steps one shared ALU and
// one memory port through FETCH/DECODE/EXEC/MEM/WB with a ready handshake.
module multicycle_ctrl #(
    parameter int RA_INDEX = 31
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;

    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    typedef enum logic [3:0] {
        K_ADD, K_SUB, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JR, K_JAL, K_ILL
    } kind_t;

    kind_t      kind;
    logic [2:0] state_q;
    logic [2:0] state_d;

    // The link register is fixed by the datapath's reg_dst=2 input.
    if (RA_INDEX < 0 || RA_INDEX > 31) begin : g_ra_range
        $error("RA_INDEX out of register-file range");
    end

    always_comb begin
        kind = K_ILL;
        case (bus.op)
            OP_RTYPE: begin
                case (bus.func)
                    FN_ADD:  kind = K_ADD;
                    FN_SUB:  kind = K_SUB;
                    FN_JR:   kind = K_JR;
                    default: kind = K_ILL;
                endcase
            end
            OP_ORI:  kind = K_ORI;
            OP_LUI:  kind = K_LUI;
            OP_LW:   kind = K_LW;
            OP_SW:   kind = K_SW;
            OP_BEQ:  kind = K_BEQ;
            OP_JAL:  kind = K_JAL;
            default: kind = K_ILL;
        endcase
    end

    assign bus.state = state_q;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_d        = FETCH;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'd0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 2'd0;
        bus.wd_sel     = 2'd0;
        bus.alu_op     = 3'b000;
        bus.ext_sel    = 1'b0;
        bus.alu_b      = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;

        case (state_q)
            FETCH: begin
                bus.mem_read = 1'b1;
                bus.alu_op   = ALU_ADD;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
                state_d      = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alu_op = ALU_ADD;
                case (kind)
                    K_JAL:   state_d = WB;
                    K_ILL: begin
                        bus.illegal    = 1'b1;
                        bus.instr_done = 1'b1;
                        state_d        = FETCH;
                    end
                    default: state_d = EXEC;
                endcase
            end
            EXEC: begin
                case (kind)
                    K_ADD: begin bus.alu_op = ALU_ADD; state_d = WB; end
                    K_SUB: begin bus.alu_op = ALU_SUB; state_d = WB; end
                    K_ORI: begin bus.alu_op = ALU_OR; bus.alu_b = 1'b1; state_d = WB; end
                    K_LUI: state_d = WB;
                    K_LW, K_SW: begin
                        bus.alu_op  = ALU_ADD;
                        bus.alu_b   = 1'b1;
                        bus.ext_sel = 1'b1;
                        state_d     = MEM;
                    end
                    K_BEQ: begin
                        bus.alu_op     = ALU_SUB;
                        bus.ext_sel    = 1'b1;
                        bus.pc_src     = 2'd1;
                        bus.pc_write   = bus.zero;
                        bus.instr_done = 1'b1;
                    end
                    K_JR: begin
                        bus.pc_src     = 2'd3;
                        bus.pc_write   = 1'b1;
                        bus.instr_done = 1'b1;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                // Requests are held unchanged on every wait cycle.
                case (kind)
                    K_LW: begin
                        bus.mem_read = 1'b1;
                        state_d      = bus.mem_ready ? WB : MEM;
                    end
                    K_SW: begin
                        bus.mem_write  = 1'b1;
                        bus.instr_done = bus.mem_ready;
                        state_d        = bus.mem_ready ? FETCH : MEM;
                    end
                    default: state_d = FETCH;
                endcase
            end
            WB: begin
                bus.instr_done = 1'b1;
                case (kind)
                    K_ADD, K_SUB: begin bus.reg_write = 1'b1; bus.reg_dst = 2'd1; end
                    K_ORI:        bus.reg_write = 1'b1;
                    K_LUI:  begin bus.reg_write = 1'b1; bus.wd_sel = 2'd2; end
                    K_LW:   begin bus.reg_write = 1'b1; bus.wd_sel = 2'd1; end
                    K_JAL: begin
                        bus.reg_write = 1'b1;
                        bus.reg_dst   = 2'd2;
                        bus.wd_sel    = 2'd3;
                        bus.pc_src    = 2'd2;
                        bus.pc_write  = 1'b1;
                    end
                    default: bus.reg_write = 1'b0;
                endcase
            end
            default: state_d = FETCH;
        endcase

        // Reset aborts the instruction in the same cycle it is raised.
        if (reset) begin
            state_d        = FETCH;
            bus.ir_write   = 1'b0;
            bus.pc_write   = 1'b0;
            bus.pc_src     = 2'd0;
            bus.mem_read   = 1'b0;
            bus.mem_write  = 1'b0;
            bus.reg_write  = 1'b0;
            bus.reg_dst    = 2'd0;
            bus.wd_sel     = 2'd0;
            bus.alu_op     = 3'b000;
            bus.ext_sel    = 1'b0;
            bus.alu_b      = 1'b0;
            bus.instr_done = 1'b0;
            bus.illegal    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs are queued
// as each step is driven and compared against the DUT before the next edge.
module tb_multicycle_ctrl;
    typedef struct packed {
        logic [2:0] state;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic [2:0] alu_op;
        logic       ext_sel;
        logic       alu_b;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    localparam logic [2:0] A_OR  = 3'b001;
    localparam logic [2:0] A_ADD = 3'b010;
    localparam logic [2:0] A_SUB = 3'b011;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    outs_t exp_q[$];
    string tag_q[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.RA_INDEX(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic outs_t mk(input logic [2:0] st, input logic irw, input logic pcw,
                                 input logic [1:0] pcs, input logic mr, input logic mw,
                                 input logic rw, input logic [1:0] rdst, input logic [1:0] wds,
                                 input logic [2:0] alu, input logic ext, input logic alub,
                                 input logic done, input logic ill);
        outs_t e;
        e = '{state: st, ir_write: irw, pc_write: pcw, pc_src: pcs, mem_read: mr,
              mem_write: mw, reg_write: rw, reg_dst: rdst, wd_sel: wds, alu_op: alu,
              ext_sel: ext, alu_b: alub, instr_done: done, illegal: ill};
        return e;
    endfunction

    function automatic outs_t sample();
        outs_t a;
        a = '{state: bus.state, ir_write: bus.ir_write, pc_write: bus.pc_write,
              pc_src: bus.pc_src, mem_read: bus.mem_read, mem_write: bus.mem_write,
              reg_write: bus.reg_write, reg_dst: bus.reg_dst, wd_sel: bus.wd_sel,
              alu_op: bus.alu_op, ext_sel: bus.ext_sel, alu_b: bus.alu_b,
              instr_done: bus.instr_done, illegal: bus.illegal};
        return a;
    endfunction

    // One clock cycle: drive inputs at the falling edge, check mid-low phase.
    task automatic cyc(input logic rst, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic r, input outs_t e, input string tag);
        outs_t act, want;
        string t;
        reset         = rst;
        bus.op        = o;
        bus.func      = f;
        bus.zero      = z;
        bus.mem_ready = r;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        act  = sample();
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        checks++;
        assert (act === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", t, act, want);
        end
        @(negedge clk);
    endtask

    task automatic fetch(input logic [5:0] o, input logic [5:0] f, input logic r);
        cyc(1'b0, o, f, 1'b0, r, mk(3'd0, r, r, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0,
                                   A_ADD, 1'b0, 1'b0, 1'b0, 1'b0), "fetch");
    endtask

    task automatic decode(input logic [5:0] o, input logic [5:0] f);
        cyc(1'b0, o, f, 1'b0, 1'b1, mk(3'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                                      A_ADD, 1'b0, 1'b0, 1'b0, 1'b0), "decode");
    endtask

    task automatic illegal_seq(input logic [5:0] o, input logic [5:0] f);
        fetch(o, f, 1'b1);
        cyc(1'b0, o, f, 1'b0, 1'b1, mk(3'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                                      A_ADD, 1'b0, 1'b0, 1'b1, 1'b1), "illegal_decode");
    endtask

    initial begin
        reset         = 1'b1;
        bus.op        = 6'h00;
        bus.func      = 6'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        cyc(1'b1, 6'h00, 6'h00, 1'b0, 1'b1, '0, "reset");

        // add: 0,1,2,4
        fetch(6'h00, 6'h20, 1'b1);
        decode(6'h00, 6'h20);
        cyc(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0,
                                              A_ADD, 0, 0, 0, 0), "add_exec");
        cyc(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, mk(3'd4, 0, 0, 2'd0, 0, 0, 1, 2'd1, 2'd0,
                                              3'b000, 0, 0, 1, 0), "add_wb");

        // lw with two wait cycles in FETCH and in MEM: 9 cycles total
        fetch(6'h23, 6'h00, 1'b0);
        fetch(6'h23, 6'h00, 1'b0);
        fetch(6'h23, 6'h00, 1'b1);
        decode(6'h23, 6'h00);
        cyc(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0,
                                              A_ADD, 1, 1, 0, 0), "lw_exec");
        for (int i = 0; i < 2; i++)
            cyc(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, mk(3'd3, 0, 0, 2'd0, 1, 0, 0, 2'd0, 2'd0,
                                                  3'b000, 0, 0, 0, 0), "lw_mem_wait");
        cyc(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, mk(3'd3, 0, 0, 2'd0, 1, 0, 0, 2'd0, 2'd0,
                                              3'b000, 0, 0, 0, 0), "lw_mem_ready");
        cyc(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, mk(3'd4, 0, 0, 2'd0, 0, 0, 1, 2'd0, 2'd1,
                                              3'b000, 0, 0, 1, 0), "lw_wb");

        // beq taken then not taken
        fetch(6'h04, 6'h00, 1'b1);
        decode(6'h04, 6'h00);
        cyc(1'b0, 6'h04, 6'h00, 1'b1, 1'b1, mk(3'd2, 0, 1, 2'd1, 0, 0, 0, 2'd0, 2'd0,
                                              A_SUB, 1, 0, 1, 0), "beq_taken");
        fetch(6'h04, 6'h00, 1'b1);
        decode(6'h04, 6'h00);
        cyc(1'b0, 6'h04, 6'h00, 1'b0, 1'b1, mk(3'd2, 0, 0, 2'd1, 0, 0, 0, 2'd0, 2'd0,
                                              A_SUB, 1, 0, 1, 0), "beq_not_taken");

        // jal 0,1,4 then jr 0,1,2
        fetch(6'h03, 6'h00, 1'b1);
        decode(6'h03, 6'h00);
        cyc(1'b0, 6'h03, 6'h00, 1'b0, 1'b1, mk(3'd4, 0, 1, 2'd2, 0, 0, 1, 2'd2, 2'd3,
                                              3'b000, 0, 0, 1, 0), "jal_wb");
        fetch(6'h00, 6'h08, 1'b1);
        decode(6'h00, 6'h08);
        cyc(1'b0, 6'h00, 6'h08, 1'b0, 1'b1, mk(3'd2, 0, 1, 2'd3, 0, 0, 0, 2'd0, 2'd0,
                                              3'b000, 0, 0, 1, 0), "jr_exec");

        // sw aborted by reset during the second MEM wait
        fetch(6'h2B, 6'h00, 1'b1);
        decode(6'h2B, 6'h00);
        cyc(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0,
                                              A_ADD, 1, 1, 0, 0), "sw_exec");
        cyc(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, mk(3'd3, 0, 0, 2'd0, 0, 1, 0, 2'd0, 2'd0,
                                              3'b000, 0, 0, 0, 0), "sw_mem_wait");
        cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, mk(3'd3, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0,
                                              3'b000, 0, 0, 0, 0), "sw_reset_abort");

        // sw completing with no wait states: 4 cycles
        fetch(6'h2B, 6'h00, 1'b1);
        decode(6'h2B, 6'h00);
        cyc(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0,
                                              A_ADD, 1, 1, 0, 0), "sw_exec2");
        cyc(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, mk(3'd3, 0, 0, 2'd0, 0, 1, 0, 2'd0, 2'd0,
                                              3'b000, 0, 0, 1, 0), "sw_mem_done");

        // unknown op, then unsupported R-type func
        illegal_seq(6'h3F, 6'h00);
        illegal_seq(6'h00, 6'h25);

        // ori, lui, sub
        fetch(6'h0D, 6'h00, 1'b1);
        decode(6'h0D, 6'h00);
        cyc(1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0,
                                              A_OR, 0, 1, 0, 0), "ori_exec");
        cyc(1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, mk(3'd4, 0, 0, 2'd0, 0, 0, 1, 2'd0, 2'd0,
                                              3'b000, 0, 0, 1, 0), "ori_wb");
        fetch(6'h0F, 6'h00, 1'b1);
        decode(6'h0F, 6'h00);
        cyc(1'b0, 6'h0F, 6'h00, 1'b0, 1'b1, mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0,
                                              3'b000, 0, 0, 0, 0), "lui_exec");
        cyc(1'b0, 6'h0F, 6'h00, 1'b0, 1'b1, mk(3'd4, 0, 0, 2'd0, 0, 0, 1, 2'd0, 2'd2,
                                              3'b000, 0, 0, 1, 0), "lui_wb");
        fetch(6'h00, 6'h22, 1'b1);
        decode(6'h00, 6'h22);
        cyc(1'b0, 6'h00, 6'h22, 1'b0, 1'b1, mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0,
                                              A_SUB, 0, 0, 0, 0), "sub_exec");
        cyc(1'b0, 6'h00, 6'h22, 1'b0, 1'b1, mk(3'd4, 0, 0, 2'd0, 0, 0, 1, 2'd1, 2'd0,
                                              3'b000, 0, 0, 1, 0), "sub_wb");
        fetch(6'h00, 6'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencing controller for the MIPS-subset core (add, sub, ori, lw, sw, beq, lui, jal, jr). It decodes the latched instruction fields and steps a shared single-ALU / single-memory datapath through FETCH, DECODE, EXEC, MEM and WB. It emits per-state enables and mux selects, and waits on a memory-ready handshake. It replaces the single-cycle decoder and sits between the IR and the datapath muxes/enables.

Parameters:
RA_INDEX, 31, register index written by jal (informational; reg_dst=2 selects it in datapath)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
op  input  6  IR[31:26], valid from DECODE onward
func  input  6  IR[5:0], valid from DECODE onward
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
ir_write  output  1  latch instruction into IR
pc_write  output  1  unconditional PC update
pc_src  output  2  0 pc+4, 1 branch target, 2 jal target, 3 rs (jr)
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register file write enable
reg_dst  output  2  0 rt, 1 rd, 2 $31
wd_sel  output  2  0 ALU result, 1 memory data, 2 {imm,16'b0}, 3 pc+4
alu_op  output  3  AND 000, OR 001, ADD 010, SUB 011
ext_sel  output  1  0 zero-extend, 1 sign-extend
alu_b  output  1  0 register B, 1 extended immediate
instr_done  output  1  one-cycle pulse in the final cycle of each instruction
illegal  output  1  one-cycle pulse in DECODE for an unrecognised op/func

Behaviour:
- All state changes occur on the rising edge of clk. Reset has priority over every other event.
- While reset is high: state<=FETCH next edge. All enables (ir_write, pc_write, mem_read, mem_write, reg_write), instr_done and illegal are forced to 0 combinationally. Selects read 0.
- Outputs are a function of the state register and op/func (Moore plus decode). Unlisted outputs are 0.
- FETCH:
  - mem_read=1, alu_op=ADD, pc_src=0.
  - If mem_ready: ir_write=1, pc_write=1, next state DECODE.
  - Else ir_write=0, pc_write=0, stay in FETCH.
- DECODE:
  - alu_op=ADD; operands are latched by the datapath.
  - add/sub/ori/lui/lw/sw/beq/jr -> EXEC.
  - jal -> WB.
  - Unknown op, or R-type with func not in {add, sub, jr}: illegal=1, instr_done=1, next FETCH. Treated as a nop; no writes.
- EXEC:
  - add: alu_op=ADD, alu_b=0 -> WB.
  - sub: alu_op=SUB, alu_b=0 -> WB.
  - ori: alu_op=OR, alu_b=1, ext_sel=0 -> WB.
  - lui: no ALU use -> WB.
  - lw/sw: alu_op=ADD, alu_b=1, ext_sel=1 -> MEM.
  - beq: alu_op=SUB, alu_b=0, ext_sel=1, pc_src=1, pc_write=zero; instr_done=1 -> FETCH.
  - jr: pc_src=3, pc_write=1, instr_done=1 -> FETCH.
- MEM:
  - lw: mem_read=1. If mem_ready -> WB, else stay.
  - sw: mem_write=1, held every wait cycle. If mem_ready: instr_done=1 -> FETCH, else stay.
  - Request signals stay stable during waits.
- WB: reg_write=1, instr_done=1, next FETCH.
  - add/sub: reg_dst=1, wd_sel=0.
  - ori: reg_dst=0, wd_sel=0.
  - lui: reg_dst=0, wd_sel=2.
  - lw: reg_dst=0, wd_sel=1.
  - jal: reg_dst=2, wd_sel=3, pc_src=2, pc_write=1. Link value is pc+4 after fetch increment.
- Cycles with zero wait states: R/ori/lui=4, lw=5, sw=4, beq=3, jr=3, jal=3, illegal=2. Each mem_ready=0 cycle adds one.
- Unreachable state codes 5-7 -> FETCH next cycle with all enables 0.
- Reset in any state, including a memory wait, aborts the instruction. No write enable is asserted in the reset cycle.

Test Plan:
- reset 1 cycle, add (op=0,func=0x20), mem_ready=1 -> states 0,1,2,4,0. EXEC alu_op=010. WB reg_write=1, reg_dst=1, wd_sel=0. instr_done only in the WB cycle.
- lw (op=0x23), mem_ready low for 2 cycles in both FETCH and MEM -> FETCH held 3 cycles with ir_write=0 until ready. MEM held 3 cycles with mem_read=1. WB wd_sel=1, reg_dst=0. Total 9 cycles.
- beq (op=0x04) with zero=1, then zero=0 -> EXEC pc_src=1. pc_write=1 for zero=1 and 0 for zero=0. Both return to FETCH after 3 cycles.
- jal (op=0x03), then jr (op=0,func=0x08):
  - jal path 0,1,4 with reg_write=1, reg_dst=2, wd_sel=3, pc_write=1, pc_src=2.
  - jr path 0,1,2 with pc_src=3, pc_write=1, reg_write=0.
- sw (op=0x2B), reset asserted during the 2nd MEM wait cycle -> mem_write=0 in the reset cycle. Next state is FETCH and no instr_done is emitted.
- op=0x3F, then R-type with func=0x25 -> illegal=1 and instr_done=1 in DECODE, no enables, back to FETCH in 2 cycles.
